// File: rtl/matrix_mem_unit_if.sv
// rtl/matrix_mem_unit_if.sv - host and MAC-engine bus bundle for matrix_mem_unit
interface matrix_mem_unit_if #(
   parameter int param_M            = 4,
   parameter int param_K            = 4,
   parameter int param_N            = 4,
   parameter int DATA_WIDTH_INITIAL = 8,
   parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
);
   // Index widths; a one-entry matrix still needs a one-bit index.
   localparam int A_AW  = (param_M * param_K > 1) ? $clog2(param_M * param_K) : 1;
   localparam int B_AW  = (param_K * param_N > 1) ? $clog2(param_K * param_N) : 1;
   localparam int C_AW  = (param_M * param_N > 1) ? $clog2(param_M * param_N) : 1;
   localparam int AB_AW = (A_AW > B_AW) ? A_AW : B_AW;

   // Host side
   logic                          host_we;
   logic                          host_sel;
   logic [AB_AW-1:0]              host_addr;
   logic [DATA_WIDTH_INITIAL-1:0] host_wdata;
   logic                          host_start;
   logic                          host_busy;
   logic                          host_done;
   logic                          host_c_re;
   logic [C_AW-1:0]               host_c_addr;
   logic [DATA_WIDTH_FINAL-1:0]   host_c_rdata;
   logic                          host_c_rvalid;

   // MAC engine side
   logic                          mac_start;
   logic                          a_b_re;
   logic [A_AW-1:0]               a_addr_in;
   logic [B_AW-1:0]               b_addr_in;
   logic [DATA_WIDTH_INITIAL-1:0] a_data_out;
   logic [DATA_WIDTH_INITIAL-1:0] b_data_out;
   logic                          c_we;
   logic [C_AW-1:0]               c_addr_in;
   logic [DATA_WIDTH_FINAL-1:0]   c_data_in;
   logic                          mac_done;

   // The memory unit
   modport slave (
      input  host_we, host_sel, host_addr, host_wdata, host_start,
      input  host_c_re, host_c_addr,
      output host_busy, host_done, host_c_rdata, host_c_rvalid,
      input  a_b_re, a_addr_in, b_addr_in, c_we, c_addr_in, c_data_in, mac_done,
      output mac_start, a_data_out, b_data_out
   );

   // The host plus engine driving the memory unit
   modport master (
      output host_we, host_sel, host_addr, host_wdata, host_start,
      output host_c_re, host_c_addr,
      input  host_busy, host_done, host_c_rdata, host_c_rvalid,
      output a_b_re, a_addr_in, b_addr_in, c_we, c_addr_in, c_data_in, mac_done,
      input  mac_start, a_data_out, b_data_out
   );
endinterface

// File: rtl/matrix_mem_unit.sv
// rtl/matrix_mem_unit.sv - A/B/C matrix store and run sequencer for the MAC engine
module matrix_mem_unit #(
   parameter int param_M            = 4,
   parameter int param_K            = 4,
   parameter int param_N            = 4,
   parameter int DATA_WIDTH_INITIAL = 8,
   parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) (
   input  logic              clk,
   input  logic              rstn,
   matrix_mem_unit_if.slave  bus
);
   localparam int A_SIZE = param_M * param_K;
   localparam int B_SIZE = param_K * param_N;
   localparam int C_SIZE = param_M * param_N;
   localparam int A_AW   = (A_SIZE > 1) ? $clog2(A_SIZE) : 1;
   localparam int B_AW   = (B_SIZE > 1) ? $clog2(B_SIZE) : 1;
   localparam int C_AW   = (C_SIZE > 1) ? $clog2(C_SIZE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                        state;
   logic                          mac_done_q;
   logic                          mac_start_q;
   logic                          host_busy_q;
   logic                          host_done_q;

   logic [DATA_WIDTH_INITIAL-1:0] mem_a [A_SIZE];
   logic [DATA_WIDTH_INITIAL-1:0] mem_b [B_SIZE];
   logic [DATA_WIDTH_FINAL-1:0]   mem_c [C_SIZE];

   logic [DATA_WIDTH_INITIAL-1:0] a_rd_q;
   logic [DATA_WIDTH_INITIAL-1:0] b_rd_q;
   logic [DATA_WIDTH_FINAL-1:0]   c_rd_q;
   logic                          c_rvalid_q;

   logic                          host_wr_ok;
   logic                          host_a_hit;
   logic                          host_b_hit;
   logic                          eng_a_hit;
   logic                          eng_b_hit;
   logic                          eng_c_hit;
   logic                          host_c_hit;

   // Host loads are only safe while the engine is not fetching operands.
   assign host_wr_ok = (state == ST_IDLE) || (state == ST_DONE);

   // Range guards only matter for non-power-of-two matrix sizes.
   assign host_a_hit = int'(bus.host_addr)   < A_SIZE;
   assign host_b_hit = int'(bus.host_addr)   < B_SIZE;
   assign eng_a_hit  = int'(bus.a_addr_in)   < A_SIZE;
   assign eng_b_hit  = int'(bus.b_addr_in)   < B_SIZE;
   assign eng_c_hit  = int'(bus.c_addr_in)   < C_SIZE;
   assign host_c_hit = int'(bus.host_c_addr) < C_SIZE;

   // Run sequencer: launch pulse, wait for a fresh rising edge of mac_done
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         mac_done_q  <= 1'b0;
         mac_start_q <= 1'b0;
         host_busy_q <= 1'b0;
         host_done_q <= 1'b0;
      end else begin
         mac_done_q <= bus.mac_done;
         case (state)
            ST_IDLE: begin
               if (bus.host_start) begin
                  state       <= ST_START;
                  mac_start_q <= 1'b1;
                  host_busy_q <= 1'b1;
               end
            end
            ST_START: begin
               state       <= ST_RUN;
               mac_start_q <= 1'b0;
            end
            ST_RUN: begin
               // Only a 0->1 transition ends the run; a level left high
               // from the previous run must not finish this one early.
               if (bus.mac_done && !mac_done_q) begin
                  state       <= ST_DONE;
                  host_busy_q <= 1'b0;
                  host_done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.host_start) begin
                  state       <= ST_START;
                  mac_start_q <= 1'b1;
                  host_busy_q <= 1'b1;
                  host_done_q <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               mac_start_q <= 1'b0;
               host_busy_q <= 1'b0;
               host_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Matrix A storage, written by the host outside a run
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < A_SIZE; i++) begin
            mem_a[i] <= '0;
         end
      end else if (bus.host_we && host_wr_ok && !bus.host_sel && host_a_hit) begin
         mem_a[bus.host_addr[A_AW-1:0]] <= bus.host_wdata;
      end
   end

   // Matrix B storage, written by the host outside a run
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < B_SIZE; i++) begin
            mem_b[i] <= '0;
         end
      end else if (bus.host_we && host_wr_ok && bus.host_sel && host_b_hit) begin
         mem_b[bus.host_addr[B_AW-1:0]] <= bus.host_wdata;
      end
   end

   // Matrix C storage, written by the engine in any state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < C_SIZE; i++) begin
            mem_c[i] <= '0;
         end
      end else if (bus.c_we && eng_c_hit) begin
         mem_c[bus.c_addr_in[C_AW-1:0]] <= bus.c_data_in;
      end
   end

   // Engine operand fetch: one-cycle latency, holds while a_b_re is low
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_rd_q <= '0;
         b_rd_q <= '0;
      end else if (bus.a_b_re) begin
         a_rd_q <= eng_a_hit ? mem_a[bus.a_addr_in[A_AW-1:0]] : '0;
         b_rd_q <= eng_b_hit ? mem_b[bus.b_addr_in[B_AW-1:0]] : '0;
      end
   end

   // Host C readback; samples mem_c before any same-edge engine write lands
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_rd_q     <= '0;
         c_rvalid_q <= 1'b0;
      end else begin
         c_rvalid_q <= bus.host_c_re;
         if (bus.host_c_re) begin
            c_rd_q <= host_c_hit ? mem_c[bus.host_c_addr[C_AW-1:0]] : '0;
         end
      end
   end

   assign bus.mac_start     = mac_start_q;
   assign bus.host_busy     = host_busy_q;
   assign bus.host_done     = host_done_q;
   assign bus.a_data_out    = a_rd_q;
   assign bus.b_data_out    = b_rd_q;
   assign bus.host_c_rdata  = c_rd_q;
   assign bus.host_c_rvalid = c_rvalid_q;
endmodule

// File: doc/matrix_mem_unit.md
Name: matrix_mem_unit

Overview:
Memory-side responder for the pipelined MAC engine. It holds matrix A (MxK, row-major), matrix B (KxN, column-major) and result matrix C (MxN, row-major). It serves the engine's A/B reads with one-cycle latency and absorbs its C writes. It also gives a host port for loading A/B, launching a run, and reading C back.

Parameters:
param_M, 4, rows of A and C
param_K, 4, columns of A and rows of B (dot-product length)
param_N, 4, columns of B and C
DATA_WIDTH_INITIAL, 8, A/B element width
DATA_WIDTH_FINAL, DATA_WIDTH_INITIAL*2, C element width
AB_AW, max($clog2(param_M*param_K),$clog2(param_K*param_N)), host A/B address width

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
host_we  in  1  host write strobe for A/B
host_sel  in  1  0 selects A, 1 selects B
host_addr  in  AB_AW  flat element index
host_wdata  in  DATA_WIDTH_INITIAL  write data
host_start  in  1  request a MAC run (sampled one cycle)
host_busy  out  1  high in START and RUN
host_done  out  1  high in DONE
host_c_re  in  1  host read strobe for C
host_c_addr  in  $clog2(param_M*param_N)  C flat index
host_c_rdata  out  DATA_WIDTH_FINAL  C read data
host_c_rvalid  out  1  host_c_rdata valid this cycle
mac_start  out  1  one-cycle launch pulse to the engine
a_b_re  in  1  engine read enable
a_addr_in  in  $clog2(param_M*param_K)  A index from engine
b_addr_in  in  $clog2(param_K*param_N)  B index from engine
a_data_out  out  DATA_WIDTH_INITIAL  registered A read data
b_data_out  out  DATA_WIDTH_INITIAL  registered B read data
c_we  in  1  engine C write enable
c_addr_in  in  $clog2(param_M*param_N)  C write index
c_data_in  in  DATA_WIDTH_FINAL  C write data
mac_done  in  1  engine completion flag (level, sticky)

Behaviour:
- Reset is asynchronous and active-low. It clears all A, B and C entries to 0.
- Reset values: every output is 0. The FSM enters IDLE and mac_done_q (registered copy of mac_done) is 0.
- FSM states:
  - IDLE: host A/B writes accepted. host_start=1 -> START.
  - START: mac_start=1 for exactly this cycle. Next state RUN unconditionally.
  - RUN: host A/B writes ignored. Exit to DONE when mac_done=1 and mac_done_q=0 (rising edge only). A sticky-high mac_done does not re-trigger.
  - DONE: host_done=1. Host A/B writes accepted. host_start=1 -> START. No auto-return to IDLE.
- Engine reads: when a_b_re=1 at edge t, a_data_out=A[a_addr_in] and b_data_out=B[b_addr_in] from edge t to t+1. When a_b_re=0, both outputs hold their last value. Reads are accepted in every state.
- Engine writes: c_we=1 writes C[c_addr_in]=c_data_in at the edge, in any state. A write and a host read to the same C index in the same cycle return the old data (read-before-write).
- Host writes: host_we=1 in IDLE or DONE writes A[host_addr] (host_sel=0) or B[host_addr] (host_sel=1). In START or RUN the write is dropped silently.
- host_we and host_start in the same IDLE cycle: the write completes and the run launches.
- Host C read: host_c_re=1 at edge t drives host_c_rdata=C[host_c_addr] and host_c_rvalid=1 for the next cycle only. host_c_rdata holds its value otherwise. Reads are allowed in all states.
- Out-of-range indices (non-power-of-two sizes): writes are ignored and reads return 0.
- Widths: data is stored exactly as written. The block does no arithmetic, saturation or extension.
- host_start outside IDLE or DONE is ignored.

Test Plan:
- Reset mid-RUN -> all outputs 0 next cycle, FSM in IDLE, A/B/C read back as 0.
- Load A=identity and B[n]=n+1 (n=0..15), pulse host_start -> mac_start high exactly 1 cycle. Then read C[1] -> 5, C[4] -> 2, C[15] -> 16, and host_done=1.
- Load all A and B entries = 255 and run -> every C entry = 63492 (truncated 260100).
- With a_b_re=1, a_addr_in=3 and A[3]=0x5A -> a_data_out=0x5A exactly one cycle later. Then drop a_b_re -> value holds.
- host_we during RUN with B[2]=7 and write data 9 -> B[2] still 7 after the run. The same write in DONE -> B[2]=9.
- Hold mac_done high in DONE, issue host_start -> START then RUN, with no false return to DONE until mac_done falls and rises again.
